// File: rtl/vx_tma_smem_arb_pkg.sv
// Shared sizing constants and a ring-index helper for the TMA shared-memory arbiter.
`default_nettype none

package vx_tma_smem_arb_pkg;

  localparam int LSU_WORD_SIZE   = 4;
  localparam int LMEM_TAG_WIDTH  = 8;
  localparam int MEM_ADDR_WIDTH  = 32;
  localparam int TMA_FLAGS_WIDTH = 4;

  // Wraps a ring offset in [0, 2n) back into [0, n) without a divider.
  function automatic int rr_wrap(input int a, input int n);
    return (a >= n) ? (a - n) : a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_tma_smem_rr_sel.sv
// Round-robin selector: first valid requester at or after ptr_i, plus the pointer that follows it.
`default_nettype none

module vx_tma_smem_rr_sel
  import vx_tma_smem_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] valid_i,
  input  logic [IDXW-1:0]     ptr_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [IDXW-1:0]     index_o,
  output logic                valid_o,
  output logic [IDXW-1:0]     next_ptr_o
);

  // Scan from farthest to nearest so the closest valid index overwrites the others.
  always_comb begin
    index_o = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (valid_i[rr_wrap(int'(ptr_i) + k, NUM_REQS)]) begin
        index_o = IDXW'(rr_wrap(int'(ptr_i) + k, NUM_REQS));
      end
    end
  end

  assign valid_o    = |valid_i;
  assign grant_o    = valid_o ? (NUM_REQS'(1) << index_o) : '0;
  assign next_ptr_o = (index_o == IDXW'(NUM_REQS - 1)) ? '0 : (index_o + IDXW'(1));

endmodule

`default_nettype wire

// File: rtl/vx_tma_smem_arb.sv
// N:1 single-outstanding arbiter toward the TMA shared-memory upsizer.
// Optional 1-entry request output buffer under macro TMA_SMEM_ARB_OUTBUF_EN.
`default_nettype none

module vx_tma_smem_arb
  import vx_tma_smem_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int DATA_SIZE   = LSU_WORD_SIZE,
  parameter int TAG_WIDTH   = LMEM_TAG_WIDTH,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH - $clog2(DATA_SIZE),
  parameter int FLAGS_WIDTH = TMA_FLAGS_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,

  input  logic [NUM_REQS-1:0]                   src_req_valid_i,
  input  logic [NUM_REQS-1:0]                   src_req_rw_i,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]   src_req_addr_i,
  input  logic [NUM_REQS-1:0][DATA_SIZE*8-1:0]  src_req_data_i,
  input  logic [NUM_REQS-1:0][DATA_SIZE-1:0]    src_req_byteen_i,
  input  logic [NUM_REQS-1:0][FLAGS_WIDTH-1:0]  src_req_flags_i,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]    src_req_tag_i,
  output logic [NUM_REQS-1:0]                   src_req_ready_o,
  output logic [NUM_REQS-1:0]                   src_rsp_valid_o,
  output logic [NUM_REQS-1:0][DATA_SIZE*8-1:0]  src_rsp_data_o,
  output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]    src_rsp_tag_o,
  input  logic [NUM_REQS-1:0]                   src_rsp_ready_i,

  output logic                                  dst_req_valid_o,
  output logic                                  dst_req_rw_o,
  output logic [ADDR_WIDTH-1:0]                 dst_req_addr_o,
  output logic [DATA_SIZE*8-1:0]                dst_req_data_o,
  output logic [DATA_SIZE-1:0]                  dst_req_byteen_o,
  output logic [FLAGS_WIDTH-1:0]                dst_req_flags_o,
  output logic [TAG_WIDTH-1:0]                  dst_req_tag_o,
  input  logic                                  dst_req_ready_i,
  input  logic                                  dst_rsp_valid_i,
  input  logic [DATA_SIZE*8-1:0]                dst_rsp_data_i,
  input  logic [TAG_WIDTH-1:0]                  dst_rsp_tag_i,
  output logic                                  dst_rsp_ready_o,
  output logic                                  spurious_rsp_o
);

  localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [IDXW-1:0]     ptr_q, ptr_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic                pend_q, pend_d;

  logic [NUM_REQS-1:0] w_sel_grant;
  logic [IDXW-1:0]     w_sel_idx;
  logic                w_sel_valid;
  logic [IDXW-1:0]     w_next_ptr;
  logic                w_pend;
  logic                w_down_ready;
  logic                w_arb_valid;
  logic                w_req_fire;
  logic                w_owner_ready;
  logic                w_rsp_fire;

  logic                   w_req_rw;
  logic [ADDR_WIDTH-1:0]  w_req_addr;
  logic [DATA_SIZE*8-1:0] w_req_data;
  logic [DATA_SIZE-1:0]   w_req_byteen;
  logic [FLAGS_WIDTH-1:0] w_req_flags;
  logic [TAG_WIDTH-1:0]   w_req_tag;

  vx_tma_smem_rr_sel #(
    .NUM_REQS (NUM_REQS),
    .IDXW     (IDXW)
  ) u_rr_sel (
    .valid_i    (src_req_valid_i),
    .ptr_i      (ptr_q),
    .grant_o    (w_sel_grant),
    .index_o    (w_sel_idx),
    .valid_o    (w_sel_valid),
    .next_ptr_o (w_next_ptr)
  );

  // Masking with reset keeps every handshake quiet during the reset cycle itself.
  assign w_pend      = pend_q & reset;
  assign w_arb_valid = w_sel_valid & ~w_pend & reset;
  assign w_req_fire  = w_arb_valid & w_down_ready;

  assign src_req_ready_o = w_sel_grant & {NUM_REQS{w_down_ready & ~w_pend & reset}};

  assign w_req_rw     = src_req_rw_i[w_sel_idx];
  assign w_req_addr   = src_req_addr_i[w_sel_idx];
  assign w_req_data   = src_req_data_i[w_sel_idx];
  assign w_req_byteen = src_req_byteen_i[w_sel_idx];
  assign w_req_flags  = src_req_flags_i[w_sel_idx];
  assign w_req_tag    = src_req_tag_i[w_sel_idx];

`ifdef TMA_SMEM_ARB_OUTBUF_EN
  logic                   buf_valid_q;
  logic                   buf_rw_q;
  logic [ADDR_WIDTH-1:0]  buf_addr_q;
  logic [DATA_SIZE*8-1:0] buf_data_q;
  logic [DATA_SIZE-1:0]   buf_byteen_q;
  logic [FLAGS_WIDTH-1:0] buf_flags_q;
  logic [TAG_WIDTH-1:0]   buf_tag_q;

  assign w_down_ready = ~buf_valid_q | dst_req_ready_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
    end else if (w_req_fire) begin
      buf_valid_q <= 1'b1;
    end else if (dst_req_ready_i) begin
      buf_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      buf_rw_q     <= w_req_rw;
      buf_addr_q   <= w_req_addr;
      buf_data_q   <= w_req_data;
      buf_byteen_q <= w_req_byteen;
      buf_flags_q  <= w_req_flags;
      buf_tag_q    <= w_req_tag;
    end
  end

  assign dst_req_valid_o  = buf_valid_q & reset;
  assign dst_req_rw_o     = buf_rw_q;
  assign dst_req_addr_o   = buf_addr_q;
  assign dst_req_data_o   = buf_data_q;
  assign dst_req_byteen_o = buf_byteen_q;
  assign dst_req_flags_o  = buf_flags_q;
  assign dst_req_tag_o    = buf_tag_q;
`else
  assign w_down_ready     = dst_req_ready_i;
  assign dst_req_valid_o  = w_arb_valid;
  assign dst_req_rw_o     = w_req_rw;
  assign dst_req_addr_o   = w_req_addr;
  assign dst_req_data_o   = w_req_data;
  assign dst_req_byteen_o = w_req_byteen;
  assign dst_req_flags_o  = w_req_flags;
  assign dst_req_tag_o    = w_req_tag;
`endif

  // A response with nothing outstanding is accepted and dropped, and flagged.
  assign w_owner_ready   = src_rsp_ready_i[owner_q];
  assign dst_rsp_ready_o = w_pend ? w_owner_ready : 1'b1;
  assign w_rsp_fire      = dst_rsp_valid_i & w_pend & w_owner_ready;
  assign spurious_rsp_o  = dst_rsp_valid_i & reset & ~pend_q;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp
    assign src_rsp_valid_o[i] = dst_rsp_valid_i & w_pend & (owner_q == IDXW'(i));
    assign src_rsp_data_o[i]  = dst_rsp_data_i;
    assign src_rsp_tag_o[i]   = dst_rsp_tag_i;
  end

  always_comb begin
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    owner_d = owner_q;
    if (w_rsp_fire) begin
      pend_d = 1'b0;
    end
    if (w_req_fire) begin
      ptr_d = w_next_ptr;
      if (!w_req_rw) begin
        pend_d  = 1'b1;
        owner_d = w_sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '0;
      pend_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

endmodule

`default_nettype wire
